// File: rtl/game_pkg.sv
// Shared definitions for the sequence game: default widths, colour encoding
// and the state encoding of the sequence RAM arbiter.
package game_pkg;

    localparam int unsigned ADDR_W_DEF     = 6;
    localparam int unsigned DATA_W_DEF     = 2;
    localparam int unsigned MAX_CONSEC_DEF = 4;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_ram.sv
// Single-port sequence RAM: synchronous write, registered read.
// The read register only updates on a read access, so it holds between reads.
module seq_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/seq_mem_arbiter.sv
// Shares the sequence RAM between the game FSM (port A) and the replay player
// (port B), and owns the sweep engine that zeroes the RAM on command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate A/B; clear_start launches a sweep
// ST_CLEAR | write zero to one address per cycle, 0 .. DEPTH-1
// ST_DONE  | single cycle, clear_done pulse, back to ST_IDLE
module seq_mem_arbiter
    import game_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid
);

    localparam logic [3:0]        MAX_C     = 4'(MAX_CONSEC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        consec;
    logic [ADDR_W-1:0] clr_addr;
    logic              arb_ok;
    logic              force_b;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;

    // clear_start beats any request in the same cycle
    assign arb_ok  = (state == ST_IDLE) && !clear_start;
    assign force_b = (consec == MAX_C);
    assign a_gnt   = arb_ok && a_req && !(b_req && force_b);
    assign b_gnt   = arb_ok && b_req && (!a_req || force_b);

    assign clear_busy = (state == ST_CLEAR);
    assign clear_done = (state == ST_DONE);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == ST_CLEAR) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (a_gnt) begin
            ram_en    = 1'b1;
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_en    = 1'b1;
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end else begin
                clr_addr <= '0;
            end
        end
    end

    // consec counts A grants taken while B sits waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            consec <= '0;
        end else if (!b_req || b_gnt) begin
            consec <= '0;
        end else if (a_gnt) begin
            consec <= consec + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_rvalid) a_hold <= ram_rdata;
            if (b_rvalid) b_hold <= ram_rdata;
        end
    end

    // RAM read data is only meaningful in the rvalid cycle; otherwise hold
    assign a_rdata = a_rvalid ? ram_rdata : a_hold;
    assign b_rdata = b_rvalid ? ram_rdata : b_hold;

    seq_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
